// File: rtl/uart_tx_scheduler_pkg.sv
// Shared framing constants and scheduler state encoding.
// Also used by uart_mouse_receiver for the same SYNC/ID framing.
package uart_tx_scheduler_pkg;

    localparam logic [7:0] FRAME_SYNC    = 8'hAA;
    localparam logic [7:0] FRAME_ID_BASE = 8'hA0;
    localparam int         MAX_N_REQ     = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR_SYN = 3'd1;
    localparam logic [2:0] ST_HDR_ID  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic [2:0] rr_index(
        input logic [2:0]  base,
        input int unsigned offset,
        input int unsigned n
    );
        int unsigned sum;
        sum = (32'(base) + offset) % n;
        return sum[2:0];
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Rotating-priority encoder: first valid index at or after rr_ptr.
// Purely combinational; the scheduler latches the result.
module tx_rr_arbiter import uart_tx_scheduler_pkg::*; #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [2:0]       rr_ptr,
    output logic [2:0]       grant,
    output logic             any_valid
);

    logic [MAX_N_REQ-1:0] valid_ext;

    assign valid_ext = MAX_N_REQ'(valid);

    // Scan from the farthest offset back to rr_ptr so the nearest valid wins
    always_comb begin
        logic [2:0] idx;
        idx       = 3'd0;
        grant     = 3'd0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = rr_index(rr_ptr, 32'(k), 32'(N_REQ));
            if (valid_ext[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular sharing of one UART transmitter.
// Frames: SYNC, ID_BASE|index, payload bytes.
module uart_tx_scheduler import uart_tx_scheduler_pkg::*; #(
    parameter int         N_REQ         = 3,
    parameter int         MAX_LEN       = 16,
    parameter int         STALL_TIMEOUT = 4096,
    parameter logic [7:0] SYNC_BYTE     = FRAME_SYNC,
    parameter logic [7:0] ID_BASE       = FRAME_ID_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_wr,
    input  logic               tx_busy,
    output logic [2:0]         grant_id,
    output logic               active,
    output logic               pkt_done,
    output logic               pkt_abort
);

    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    logic [2:0]             state;
    logic [2:0]             rr_ptr;
    logic [2:0]             arb_grant;
    logic                   arb_any;
    logic [1:0]             hold_cnt;
    logic [7:0]             len;
    logic [SW-1:0]          stall_cnt;
    logic                   pacer_free;
    logic [MAX_N_REQ-1:0]   valid_ext;
    logic [MAX_N_REQ-1:0]   last_ext;
    logic [8*MAX_N_REQ-1:0] data_ext;
    logic                   g_valid;
    logic                   g_last;
    logic [7:0]             g_data;
    logic                   accept;
    logic                   stall;
    logic                   issue;
    logic [7:0]             issue_byte;
    logic [2:0]             next_rr;

    tx_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .any_valid (arb_any)
    );

    assign valid_ext  = MAX_N_REQ'(req_valid);
    assign last_ext   = MAX_N_REQ'(req_last);
    assign data_ext   = (8*MAX_N_REQ)'(req_data);
    assign g_valid    = valid_ext[grant_id];
    assign g_last     = last_ext[grant_id];
    assign g_data     = data_ext[{grant_id, 3'b000} +: 8];
    assign pacer_free = !tx_busy && (hold_cnt == 2'd0);
    assign accept     = (state == ST_PAYLOAD) && pacer_free && g_valid;
    assign stall      = (state == ST_PAYLOAD) && pacer_free && !g_valid;
    assign next_rr    = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

    // Only the granted requester can see ready, and only when a byte can go out
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (grant_id == 3'(i));
        end
    end

    // Select which byte, if any, the pacer launches this cycle
    always_comb begin
        issue      = 1'b0;
        issue_byte = 8'h00;
        if (state == ST_HDR_SYN && pacer_free) begin
            issue      = 1'b1;
            issue_byte = SYNC_BYTE;
        end else if (state == ST_HDR_ID && pacer_free) begin
            issue      = 1'b1;
            issue_byte = ID_BASE | {5'd0, grant_id};
        end else if (accept) begin
            issue      = 1'b1;
            issue_byte = g_data;
        end
    end

    // Pacer: register the byte, pulse tx_wr, mask tx_busy for two cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
            hold_cnt <= 2'd0;
        end else begin
            tx_wr <= issue;
            if (issue) begin
                tx_data  <= issue_byte;
                hold_cnt <= 2'd2;
            end else if (hold_cnt != 2'd0) begin
                hold_cnt <= hold_cnt - 2'd1;
            end
        end
    end

    // Packet FSM with length and stall counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= 3'd0;
            grant_id  <= 3'd0;
            active    <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            len       <= 8'd0;
            stall_cnt <= '0;
        end else begin
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id <= arb_grant;
                        active   <= 1'b1;
                        state    <= ST_HDR_SYN;
                    end
                end
                ST_HDR_SYN: begin
                    if (pacer_free) state <= ST_HDR_ID;
                end
                ST_HDR_ID: begin
                    if (pacer_free) begin
                        len       <= 8'd0;
                        stall_cnt <= '0;
                        state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        len       <= len + 8'd1;
                        stall_cnt <= '0;
                        if (g_last) begin
                            pkt_done <= 1'b1;
                            state    <= ST_DONE;
                        end else if (len == 8'(MAX_LEN - 1)) begin
                            pkt_abort <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if (stall) begin
                        if (stall_cnt == SW'(STALL_TIMEOUT - 1)) begin
                            pkt_abort <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rr_ptr <= next_rr;
                    active <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a 10-cycle/byte UART busy model.
// Table-driven single-packet vectors plus hand sequences for arbitration, stall, reset.
module tb_uart_tx_scheduler;

    localparam int N     = 3;
    localparam int MAXL  = 16;
    localparam int STALL = 100;
    localparam int BUSY  = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           tx_busy;
    logic [2:0]     grant_id;
    logic           active;
    logic           pkt_done;
    logic           pkt_abort;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ(N), .MAX_LEN(MAXL), .STALL_TIMEOUT(STALL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active),
        .pkt_done(pkt_done), .pkt_abort(pkt_abort)
    );

    // UART model: busy for BUSY cycles starting the cycle after tx_wr
    int busy_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (tx_wr) busy_cnt <= BUSY;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Byte sources
    int         acc[N];
    int         src_base[N];
    int         src_len[N];
    logic       src_en[N];
    logic       src_le[N];
    logic [7:0] src_first[N];
    logic [7:0] src_step[N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (req_ready[i]) acc[i] <= acc[i] + 1;
    end

    always @* begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = acc[i] - src_base[i];
            req_valid[i] = src_en[i] && (pos < src_len[i]);
            req_last[i]  = req_valid[i] && src_le[i] && (pos == src_len[i] - 1);
            req_data[8*i +: 8] = src_first[i] + 8'(pos) * src_step[i];
        end
    end

    // Monitor: capture bytes, count pulses, check tx_wr pacing
    logic [7:0] txq[$];
    int   cyc = 0;
    int   last_wr_cyc = -100;
    int   abort_cyc = 0;
    int   done_n = 0;
    int   abort_n = 0;
    logic prev_wr = 1'b0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pkt_done) done_n = done_n + 1;
        if (pkt_abort) begin
            abort_n = abort_n + 1;
            abort_cyc = cyc;
        end
        if (pkt_done || pkt_abort) begin
            n_cmp = n_cmp + 1;
            if (pkt_done && pkt_abort) begin
                n_bad = n_bad + 1;
                $display("FAIL done_abort_both: done=%0b abort=%0b need not both", pkt_done, pkt_abort);
            end
        end
        if (tx_wr) begin
            txq.push_back(tx_data);
            n_cmp = n_cmp + 1;
            if (prev_wr || prev_busy || (cyc - last_wr_cyc) < 3) begin
                n_bad = n_bad + 1;
                $display("FAIL pacing: prev_wr=%0b busy_at_issue=%0b gap=%0d need 0/0/>=3",
                         prev_wr, prev_busy, cyc - last_wr_cyc);
            end
            last_wr_cyc = cyc;
        end
        prev_wr   = tx_wr;
        prev_busy = tx_busy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int i, input int n, input logic le,
                        input logic [7:0] f, input logic [7:0] s);
        src_base[i]  = acc[i];
        src_len[i]   = n;
        src_le[i]    = le;
        src_first[i] = f;
        src_step[i]  = s;
        src_en[i]    = 1'b1;
    endtask

    task automatic stop_all();
        for (int i = 0; i < N; i++) src_en[i] = 1'b0;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int k;
        k = 0;
        while ((done_n + abort_n) < target && k < budget) begin
            step();
            k++;
        end
        n_cmp = n_cmp + 1;
        if ((done_n + abort_n) < target) begin
            n_bad = n_bad + 1;
            $display("FAIL pkt_timeout: got %0d packets expected %0d", done_n + abort_n, target);
        end
    endtask

    typedef struct {
        int         req;
        int         n;
        logic       le;
        logic [7:0] first;
        logic [7:0] stp;
        int         exp_tx;
        int         exp_done;
        int         exp_abort;
        int         exp_acc;
        int         exp_rr;
    } vec_t;

    vec_t vt[5];

    initial begin
        int d0, a0, base;
        logic [7:0] e;
        logic [7:0] exp_arb[9];
        logic [7:0] exp_rst[6];

        vt[0] = '{1, 3,  1'b1, 8'h11, 8'h11, 5,  1, 0, 3,  2};
        vt[1] = '{0, 17, 1'b0, 8'h01, 8'h01, 18, 0, 1, 16, 1};
        vt[2] = '{2, 1,  1'b1, 8'h5A, 8'h00, 3,  1, 0, 1,  0};
        vt[3] = '{1, 16, 1'b1, 8'h80, 8'h03, 18, 1, 0, 16, 2};
        vt[4] = '{0, 2,  1'b1, 8'hC0, 8'h01, 4,  1, 0, 2,  1};
        exp_arb = '{8'hAA, 8'hA2, 8'h70, 8'h71, 8'hAA, 8'hA0, 8'h50, 8'h51, 8'h52};
        exp_rst = '{8'hAA, 8'hA0, 8'hE0, 8'hAA, 8'hA2, 8'hE1};

        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b0; src_len[i] = 0; src_le[i] = 1'b0;
            src_first[i] = 8'h00; src_step[i] = 8'h00; src_base[i] = 0;
        end

        // Reset state
        repeat (3) step();
        chk("rst_tx_wr", int'(tx_wr), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_done", int'(pkt_done), 0);
        chk("rst_abort", int'(pkt_abort), 0);
        reset = 1'b0;
        repeat (2) step();

        // Single-packet table
        for (int v = 0; v < 5; v++) begin
            txq.delete();
            d0 = done_n;
            a0 = abort_n;
            load(vt[v].req, vt[v].n, vt[v].le, vt[v].first, vt[v].stp);
            wait_pkts(d0 + a0 + 1, 2000);
            stop_all();
            repeat (2) step();
            chk($sformatf("v%0d_txlen", v), txq.size(), vt[v].exp_tx);
            for (int k = 0; k < txq.size() && k < vt[v].exp_tx; k++) begin
                if (k == 0) e = 8'hAA;
                else if (k == 1) e = 8'hA0 | 8'(vt[v].req);
                else e = vt[v].first + 8'(k - 2) * vt[v].stp;
                chk($sformatf("v%0d_byte%0d", v, k), int'(txq[k]), int'(e));
            end
            chk($sformatf("v%0d_done", v), done_n - d0, vt[v].exp_done);
            chk($sformatf("v%0d_abort", v), abort_n - a0, vt[v].exp_abort);
            chk($sformatf("v%0d_grant", v), int'(grant_id), vt[v].req);
            chk($sformatf("v%0d_active", v), int'(active), 0);
            chk($sformatf("v%0d_accepted", v), acc[vt[v].req] - src_base[vt[v].req], vt[v].exp_acc);
            chk($sformatf("v%0d_rr", v), int'(dut.rr_ptr), vt[v].exp_rr);
        end

        // Arbitration: rr_ptr=1, req0 and req2 together -> req2 first, no interleave
        txq.delete();
        base = done_n + abort_n;
        load(0, 3, 1'b1, 8'h50, 8'h01);
        load(2, 2, 1'b1, 8'h70, 8'h01);
        wait_pkts(base + 2, 3000);
        stop_all();
        repeat (2) step();
        chk("arb_txlen", txq.size(), 9);
        for (int k = 0; k < 9 && k < txq.size(); k++)
            chk($sformatf("arb_byte%0d", k), int'(txq[k]), int'(exp_arb[k]));
        chk("arb_rr", int'(dut.rr_ptr), 1);

        // Stall timeout: req2 withholds valid after 2 bytes
        txq.delete();
        d0 = done_n;
        a0 = abort_n;
        load(2, 2, 1'b0, 8'h33, 8'h11);
        wait_pkts(d0 + a0 + 1, 3000);
        stop_all();
        repeat (2) step();
        chk("stall_abort", abort_n - a0, 1);
        chk("stall_done", done_n - d0, 0);
        chk("stall_delay", abort_cyc - last_wr_cyc, 1 + BUSY + STALL);
        chk("stall_active", int'(active), 0);
        repeat (20) step();
        chk("stall_txlen", txq.size(), 4);

        // Move rr_ptr off zero before the reset test
        base = done_n + abort_n;
        load(0, 1, 1'b1, 8'h99, 8'h00);
        wait_pkts(base + 1, 2000);
        stop_all();
        repeat (2) step();
        chk("pre_rst_rr", int'(dut.rr_ptr), 1);

        // Reset in the middle of a payload
        txq.delete();
        load(2, 8, 1'b0, 8'h40, 8'h01);
        begin
            int k;
            k = 0;
            while (!(tx_wr && txq.size() >= 4) && k < 2000) begin
                step();
                k++;
            end
        end
        chk("mid_pkt_reached", int'(tx_wr), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_tx_wr", int'(tx_wr), 0);
        chk("rst_mid_active", int'(active), 0);
        stop_all();
        repeat (2) step();
        chk("rst_mid_rr", int'(dut.rr_ptr), 0);
        reset = 1'b0;
        repeat (2) step();

        // After reset: rr_ptr=0 so req0 beats req2, frames restart with AA
        txq.delete();
        base = done_n + abort_n;
        load(2, 1, 1'b1, 8'hE1, 8'h00);
        load(0, 1, 1'b1, 8'hE0, 8'h00);
        wait_pkts(base + 2, 2000);
        stop_all();
        repeat (2) step();
        chk("post_rst_txlen", txq.size(), 6);
        for (int k = 0; k < 6 && k < txq.size(); k++)
            chk($sformatf("post_rst_byte%0d", k), int'(txq[k]), int'(exp_rst[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
